ex_stage: RTL and testbench

//  Execute stage; sits directly upstream of the MEM stage in the 5-stage pipeline.

---
 rtl/ex_stage.sv | 185 ++++++++++++++++++
 tb/tb_ex_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage pipeline, directly upstream of MEM.
//   Registers id_to_ex_bus, evaluates a single-cycle ALU and drives the data SRAM request.
//   Emits ex_to_mem_bus in the MEM stage's 76-bit layout.
//   A 32-step radix-2 restoring divider holds the front end via stallreq_for_ex.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall[5:0]        per-stage stall vector; stall[2]=EX, stall[3]=MEM, 1 = stop
//   id_to_ex_bus      {pc, op, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, src1, src2, st_data}
//   ex_to_mem_bus     {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   data_sram_*       data SRAM enable / byte write enables / address / store data
//   stallreq_for_ex   high while the divider is accepting or iterating
//   ex_to_id          {rf_we, rf_waddr, ex_result} bypass to ID
// Build option: define EX_TO_ID_FWD_EN to generate the ex_to_id bypass; otherwise it is 0.
module ex_stage #(
  parameter int unsigned DIV_ITER = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [143:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex,
  output logic [37:0]  ex_to_id
);

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;
  localparam int unsigned CntW = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_ITER - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  // Input register
  logic [143:0] bus_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q <= '0;
    end else if (stall[2] == Stop && stall[3] == NoStop) begin
      bus_q <= '0;
    end else if (stall[2] == NoStop) begin
      bus_q <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, src1, src2, st_data;
  logic [3:0]  op, ram_wen;
  logic        ram_en, sel_rf_res, rf_we;
  logic [4:0]  rf_waddr;

  assign pc         = bus_q[143:112];
  assign op         = bus_q[111:108];
  assign ram_en     = bus_q[107];
  assign ram_wen    = bus_q[106:103];
  assign sel_rf_res = bus_q[102];
  assign rf_we      = bus_q[101];
  assign rf_waddr   = bus_q[100:96];
  assign src1       = bus_q[95:64];
  assign src2       = bus_q[63:32];
  assign st_data    = bus_q[31:0];

  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // Divider
  div_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic            neg_q, neg_d;

  logic        is_div, signed_div;
  logic [31:0] abs1, abs2, div_res;
  logic [32:0] trial, diff;
  logic        ge;

  assign is_div     = (op == 4'd11) || (op == 4'd12);
  assign signed_div = (op == 4'd12);
  assign abs1       = (signed_div && src1[31]) ? -src1 : src1;
  assign abs2       = (signed_div && src2[31]) ? -src2 : src2;

  // quo_q doubles as the dividend shift register; quotient bits shift in from the right
  assign trial   = {rem_q, quo_q[31]};
  assign ge      = trial >= {1'b0, dsr_q};
  assign diff    = trial - {1'b0, dsr_q};
  assign div_res = neg_q ? -quo_q : quo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    dsr_d           = dsr_q;
    neg_d           = neg_q;
    stallreq_for_ex = 1'b0;
    case (state_q)
      StIdle: begin
        if (is_div) begin
          stallreq_for_ex = 1'b1;
          quo_d   = abs1;
          dsr_d   = abs2;
          rem_d   = '0;
          cnt_d   = '0;
          // A zero divisor yields all-ones for both ops, so never negate it
          neg_d   = signed_div && (src1[31] ^ src2[31]) && (src2 != 32'b0);
          state_d = StBusy;
        end
      end
      StBusy: begin
        stallreq_for_ex = 1'b1;
        rem_d = ge ? diff[31:0] : trial[31:0];
        quo_d = {quo_q[30:0], ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone: begin
        if (stall[2] == NoStop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU
  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:  alu_res = src1 + src2;
      4'd1:  alu_res = src1 - src2;
      4'd2:  alu_res = src1 & src2;
      4'd3:  alu_res = src1 | src2;
      4'd4:  alu_res = src1 ^ src2;
      4'd5:  alu_res = src1 << src2[4:0];
      4'd6:  alu_res = src1 >> src2[4:0];
      4'd7:  alu_res = $signed(src1) >>> src2[4:0];
      4'd8:  alu_res = {31'b0, $signed(src1) < $signed(src2)};
      4'd9:  alu_res = {31'b0, src1 < src2};
      4'd10: alu_res = {src2[15:0], 16'b0};
      4'd11,
      4'd12: alu_res = (state_q == StDone) ? div_res : 32'b0;
      default: alu_res = '0;
    endcase
  end

  // A divide in flight only commits once the quotient is ready; until then MEM sees a bubble
  logic commit_ok;
  assign commit_ok = !is_div || (state_q == StDone);

  assign ex_to_mem_bus = {pc, ram_en & commit_ok, ram_wen, sel_rf_res, rf_we & commit_ok,
                          rf_waddr, alu_res};

  assign data_sram_en    = ram_en;
  assign data_sram_wen   = ram_en ? ram_wen : 4'b0;
  assign data_sram_addr  = src1 + src2;
  assign data_sram_wdata = st_data;

`ifdef EX_TO_ID_FWD_EN
  assign ex_to_id = {rf_we & commit_ok, rf_waddr, alu_res};
`else
  assign ex_to_id = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: scoreboard of expected MEM-bus words and bypass values.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   tb_stall;
  logic [5:0]   stall;
  logic [143:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         stallreq_for_ex;
  logic [37:0]  ex_to_id;

  always #5 clk = ~clk;

  // Stands in for the hazard controller: a divide stalls IF..MEM register updates
  assign stall = stallreq_for_ex ? 6'b001111 : tb_stall;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex),
    .ex_to_id        (ex_to_id)
  );

  typedef struct {
    logic [75:0] bus;
    logic [37:0] fwd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [143:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                      input logic ram_en, input logic [3:0] wen,
                                      input logic we, input logic [4:0] wa,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] st);
    return {pc, op, ram_en, wen, 1'b0, we, wa, s1, s2, st};
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] pc, input logic ram_en,
                                  input logic [3:0] wen, input logic we,
                                  input logic [4:0] wa, input logic [31:0] res);
    exp_t e;
    e.bus = {pc, ram_en, wen, 1'b0, we, wa, res};
`ifdef EX_TO_ID_FWD_EN
    e.fwd = {we, wa, res};
`else
    e.fwd = '0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tb_stall = '0;
    id_to_ex_bus = mk(32'h40, 4'd0, 1'b1, 4'hF, 1'b1, 5'd3, 32'h11, 32'h22, 32'h33);
    tick();
    tick();
    n_vec++;
    if (ex_to_mem_bus !== 76'b0) begin
      n_err++; $display("FAIL reset_bus: got %h want 0", ex_to_mem_bus);
    end
    n_vec++;
    if (data_sram_en !== 1'b0 || data_sram_addr !== 32'b0) begin
      n_err++; $display("FAIL reset_sram: got en=%b addr=%h want 0", data_sram_en, data_sram_addr);
    end
    n_vec++;
    if (stallreq_for_ex !== 1'b0) begin
      n_err++; $display("FAIL reset_stallreq: got %b want 0", stallreq_for_ex);
    end
    n_vec++;
    if (ex_to_id !== 38'b0) begin
      n_err++; $display("FAIL reset_ex_to_id: got %h want 0", ex_to_id);
    end
    rst = 1'b0;
    id_to_ex_bus = '0;
    tick();
  endtask

  // Issued back to back, one instruction per cycle
  task automatic test_alu();
    logic [3:0]  ops [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                              4'd10, 4'd13, 4'd8, 4'd1};
    logic [31:0] s1s [14] = '{32'h7FFFFFFF, 32'h0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hAAAA5555,
                              32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hDEADBEEF, 32'h5, 32'h1, 32'h5};
    logic [31:0] s2s [14] = '{32'h1, 32'h1, 32'hFF00FF00, 32'h0F0F0000, 32'hFFFF0000,
                              32'h3F, 32'h4, 32'h24, 32'h1, 32'h1,
                              32'hABCD1234, 32'h6, 32'hFFFFFFFF, 32'h7};
    logic [31:0] res [14] = '{32'h80000000, 32'hFFFFFFFF, 32'hF000F000, 32'hFFFFF0F0,
                              32'h55555555, 32'h80000000, 32'h08000000, 32'hF8000000,
                              32'h1, 32'h0, 32'h12340000, 32'h0, 32'h0, 32'hFFFFFFFE};
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      id_to_ex_bus = mk(32'h100 + 32'(4 * i), ops[i], 1'b0, 4'h0, 1'b1, 5'(i + 5),
                        s1s[i], s2s[i], 32'h0);
      sb.push_back(mk_exp(32'h100 + 32'(4 * i), 1'b0, 4'h0, 1'b1, 5'(i + 5), res[i]));
      tick();
      e = sb.pop_front();
      n_vec++;
      if (ex_to_mem_bus !== e.bus) begin
        n_err++; $display("FAIL alu_op%0d_bus: got %h want %h", ops[i], ex_to_mem_bus, e.bus);
      end
      n_vec++;
      if (ex_to_id !== e.fwd) begin
        n_err++; $display("FAIL alu_op%0d_fwd: got %h want %h", ops[i], ex_to_id, e.fwd);
      end
    end
    id_to_ex_bus = '0;
    tick();
  endtask

  task automatic test_store();
    id_to_ex_bus = mk(32'h200, 4'd0, 1'b1, 4'hF, 1'b0, 5'd0, 32'h1000, 32'h8, 32'hDEADBEEF);
    tick();
    n_vec++;
    if ({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata} !==
        {1'b1, 4'hF, 32'h1008, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL store_sram: got en=%b wen=%h addr=%h wdata=%h want 1 f 1008 deadbeef",
                        data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
    end
    n_vec++;
    if (ex_to_mem_bus[43:39] !== 5'b11111) begin
      n_err++; $display("FAIL store_bus_ram: got %b want 11111", ex_to_mem_bus[43:39]);
    end
    // Byte enables must be gated off when the SRAM is not enabled
    id_to_ex_bus = mk(32'h204, 4'd0, 1'b0, 4'hF, 1'b0, 5'd0, 32'h20, 32'h4, 32'h12345678);
    tick();
    n_vec++;
    if ({data_sram_en, data_sram_wen, data_sram_addr} !== {1'b0, 4'h0, 32'h24}) begin
      n_err++; $display("FAIL wen_gate: got en=%b wen=%h addr=%h want 0 0 24",
                        data_sram_en, data_sram_wen, data_sram_addr);
    end
    id_to_ex_bus = '0;
    tick();
  endtask

  task automatic test_div();
    logic [3:0]  ops [7] = '{4'd12, 4'd11, 4'd12, 4'd12, 4'd11, 4'd12, 4'd11};
    logic [31:0] s1s [7] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFF,
                             32'h7, 32'hF0000000};
    logic [31:0] s2s [7] = '{32'h2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h3, 32'hFFFFFFFE, 32'h10};
    logic [31:0] res [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                             32'h55555555, 32'hFFFFFFFD, 32'h0F000000};
    exp_t e;
    int   hi;
    logic leak;
    for (int i = 0; i < 7; i++) begin
      tb_stall = '0;
      id_to_ex_bus = mk(32'h300 + 32'(4 * i), ops[i], 1'b0, 4'h0, 1'b1, 5'd9,
                        s1s[i], s2s[i], 32'h0);
      sb.push_back(mk_exp(32'h300 + 32'(4 * i), 1'b0, 4'h0, 1'b1, 5'd9, res[i]));
      tick();
      id_to_ex_bus = '0;
      hi = 0;
      leak = 1'b0;
      for (int c = 0; c < 40 && stallreq_for_ex === 1'b1; c++) begin
        hi++;
        if (ex_to_mem_bus[37] !== 1'b0 || ex_to_mem_bus[43] !== 1'b0 || ex_to_id[37] !== 1'b0)
          leak = 1'b1;
        tick();
      end
      e = sb.pop_front();
      n_vec++;
      if (hi != 33) begin
        n_err++; $display("FAIL div%0d_stall_cycles: got %0d want 33", i, hi);
      end
      n_vec++;
      if (leak !== 1'b0) begin
        n_err++; $display("FAIL div%0d_busy_bubble: got we/ram_en leak=%b want 0", i, leak);
      end
      n_vec++;
      if (ex_to_mem_bus !== e.bus) begin
        n_err++; $display("FAIL div%0d_result: got %h want %h", i, ex_to_mem_bus, e.bus);
      end
      n_vec++;
      if (ex_to_id !== e.fwd) begin
        n_err++; $display("FAIL div%0d_fwd: got %h want %h", i, ex_to_id, e.fwd);
      end
      if (i == 0) begin
        // DONE is held while EX is stopped
        tb_stall = 6'b001111;
        tick();
        tick();
        n_vec++;
        if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus !== e.bus) begin
          n_err++; $display("FAIL div_done_hold: got req=%b bus=%h want 0 %h",
                            stallreq_for_ex, ex_to_mem_bus, e.bus);
        end
        tb_stall = '0;
      end
      tick();
      n_vec++;
      if (ex_to_mem_bus !== 76'b0 || stallreq_for_ex !== 1'b0) begin
        n_err++; $display("FAIL div%0d_release: got req=%b bus=%h want 0 0",
                          i, stallreq_for_ex, ex_to_mem_bus);
      end
    end
  endtask

  task automatic test_stall();
    logic [143:0] ia, ib;
    exp_t e;
    ia = mk(32'h400, 4'd0, 1'b0, 4'h0, 1'b1, 5'd1, 32'd3, 32'd4, 32'h0);
    ib = mk(32'h404, 4'd0, 1'b0, 4'h0, 1'b1, 5'd2, 32'd10, 32'd20, 32'h0);
    tb_stall = '0;
    id_to_ex_bus = ia;
    sb.push_back(mk_exp(32'h400, 1'b0, 4'h0, 1'b1, 5'd1, 32'd7));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (ex_to_mem_bus !== e.bus) begin
      n_err++; $display("FAIL stall_load_a: got %h want %h", ex_to_mem_bus, e.bus);
    end
    tb_stall = 6'b000100;
    id_to_ex_bus = ib;
    tick();
    n_vec++;
    if (ex_to_mem_bus !== 76'b0 || ex_to_id !== 38'b0) begin
      n_err++; $display("FAIL stall_bubble: got %h / %h want 0", ex_to_mem_bus, ex_to_id);
    end
    tb_stall = '0;
    id_to_ex_bus = ia;
    sb.push_back(mk_exp(32'h400, 1'b0, 4'h0, 1'b1, 5'd1, 32'd7));
    tick();
    tb_stall = 6'b001100;
    id_to_ex_bus = ib;
    tick();
    tick();
    e = sb.pop_front();
    n_vec++;
    if (ex_to_mem_bus !== e.bus) begin
      n_err++; $display("FAIL stall_hold: got %h want %h", ex_to_mem_bus, e.bus);
    end
    tb_stall = '0;
    sb.push_back(mk_exp(32'h404, 1'b0, 4'h0, 1'b1, 5'd2, 32'd30));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (ex_to_mem_bus !== e.bus) begin
      n_err++; $display("FAIL stall_resume: got %h want %h", ex_to_mem_bus, e.bus);
    end
    id_to_ex_bus = '0;
    tick();
  endtask

  task automatic test_reset_mid_div();
    exp_t e;
    tb_stall = '0;
    id_to_ex_bus = mk(32'h500, 4'd12, 1'b0, 4'h0, 1'b1, 5'd4, 32'd100, 32'd7, 32'h0);
    tick();
    id_to_ex_bus = '0;
    for (int c = 0; c < 11; c++) tick();
    n_vec++;
    if (stallreq_for_ex !== 1'b1 || ex_to_id[37] !== 1'b0) begin
      n_err++; $display("FAIL busy_cnt10: got req=%b fwd_we=%b want 1 0",
                        stallreq_for_ex, ex_to_id[37]);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (stallreq_for_ex !== 1'b0 || ex_to_mem_bus !== 76'b0 || ex_to_id !== 38'b0) begin
      n_err++; $display("FAIL rst_mid_div: got req=%b bus=%h fwd=%h want 0 0 0",
                        stallreq_for_ex, ex_to_mem_bus, ex_to_id);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (stallreq_for_ex !== 1'b0) begin
      n_err++; $display("FAIL rst_div_idle: got req=%b want 0", stallreq_for_ex);
    end
    id_to_ex_bus = mk(32'h504, 4'd4, 1'b0, 4'h0, 1'b1, 5'd6, 32'h0F0F, 32'h00FF, 32'h0);
    sb.push_back(mk_exp(32'h504, 1'b0, 4'h0, 1'b1, 5'd6, 32'h0FF0));
    tick();
    e = sb.pop_front();
    n_vec++;
    if (ex_to_mem_bus !== e.bus) begin
      n_err++; $display("FAIL post_rst_alu: got %h want %h", ex_to_mem_bus, e.bus);
    end
    id_to_ex_bus = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    tb_stall = '0;
    id_to_ex_bus = '0;
    test_reset();
    test_alu();
    test_store();
    test_div();
    test_stall();
    test_reset_mid_div();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
